// File: rtl/rv_writeback.sv
// rv_writeback: uRV writeback stage with load alignment, memory-wait FSM and access timeout.
module rv_writeback #(
  parameter int g_load_timeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        w_stall_i,
  output logic        w_stall_req_o,
  input  logic        x_valid_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_rd_shifter_i,
  input  logic [31:0] x_rd_multiply_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        w_bus_error_o
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;
  state_t state;
  logic [31:0] cnt;
  logic [4:0] rd_q;
  logic rd_write_q;
  logic [2:0] fun_q;
  logic [1:0] a_q;
  logic accept, timeout;
  logic [31:0] src_value;
  function automatic logic [31:0] align(input logic [2:0] fun, input logic [1:0] a, input logic [31:0] d);
    logic [7:0] b;
    logic [15:0] h;
    b = 8'(d >> {a, 3'b000});
    h = a[1] ? d[31:16] : d[15:0];
    case (fun)
      3'b000: align = {{24{b[7]}}, b};
      3'b001: align = {{16{h[15]}}, h};
      3'b010: align = d;
      3'b100: align = {24'b0, b};
      3'b101: align = {16'b0, h};
      default: align = '0;
    endcase
  endfunction
  assign accept = x_valid_i & ~w_stall_i & (state == IDLE);
  assign timeout = (g_load_timeout != 0) && (state != IDLE) && (cnt == 32'(g_load_timeout - 1));
  assign src_value = x_rd_source_i == 2'd2 ? x_rd_shifter_i :
                     x_rd_source_i == 2'd3 ? x_rd_multiply_i : x_rd_value_i;
  assign w_stall_req_o = (state == LOAD_WAIT && !dm_load_done_i) || (state == STORE_WAIT && !dm_store_done_i);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      rd_q <= '0;
      rd_write_q <= 1'b0;
      fun_q <= '0;
      a_q <= '0;
      rf_rd_o <= '0;
      rf_rd_value_o <= '0;
      rf_rd_write_o <= 1'b0;
      w_bus_error_o <= 1'b0;
    end else begin
      rf_rd_write_o <= 1'b0;
      w_bus_error_o <= 1'b0;
      cnt <= cnt + 32'd1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            rd_q <= x_rd_i;
            rd_write_q <= x_rd_write_i;
            fun_q <= x_fun_i;
            a_q <= x_dm_addr_i[1:0];
            if (x_load_i && !dm_load_done_i) state <= LOAD_WAIT;
            else if (x_store_i && !x_load_i) state <= dm_store_done_i ? IDLE : STORE_WAIT;
            else begin
              rf_rd_o <= x_rd_i;
              rf_rd_value_o <= x_load_i ? align(x_fun_i, x_dm_addr_i[1:0], dm_data_l_i) : src_value;
              rf_rd_write_o <= x_rd_write_i & |x_rd_i;
            end
          end
        end
        LOAD_WAIT:
          if (dm_load_done_i || timeout) begin
            state <= IDLE;
            rf_rd_o <= rd_q;
            rf_rd_value_o <= dm_load_done_i ? align(fun_q, a_q, dm_data_l_i) : '0;
            rf_rd_write_o <= rd_write_q & |rd_q;
            w_bus_error_o <= ~dm_load_done_i;
          end
        STORE_WAIT:
          if (dm_store_done_i || timeout) begin
            state <= IDLE;
            w_bus_error_o <= ~dm_store_done_i;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rv_writeback.sv
// tb_rv_writeback: directed self-checking bench for rv_writeback with a 4-cycle timeout.
module tb_rv_writeback;
  logic clk_i, rst_i, w_stall_i, w_stall_req_o, x_valid_i, x_load_i, x_store_i, x_rd_write_i;
  logic [2:0] x_fun_i;
  logic [4:0] x_rd_i, rf_rd_o;
  logic [1:0] x_rd_source_i;
  logic [31:0] x_rd_value_i, x_rd_shifter_i, x_rd_multiply_i, x_dm_addr_i, dm_data_l_i, rf_rd_value_o;
  logic dm_load_done_i, dm_store_done_i, rf_rd_write_o, w_bus_error_o;
  int total = 0, fails = 0;
  rv_writeback #(.g_load_timeout(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .w_stall_i(w_stall_i), .w_stall_req_o(w_stall_req_o),
    .x_valid_i(x_valid_i), .x_fun_i(x_fun_i), .x_load_i(x_load_i), .x_store_i(x_store_i),
    .x_rd_i(x_rd_i), .x_rd_write_i(x_rd_write_i), .x_rd_source_i(x_rd_source_i),
    .x_rd_value_i(x_rd_value_i), .x_rd_shifter_i(x_rd_shifter_i), .x_rd_multiply_i(x_rd_multiply_i),
    .x_dm_addr_i(x_dm_addr_i), .dm_data_l_i(dm_data_l_i), .dm_load_done_i(dm_load_done_i),
    .dm_store_done_i(dm_store_done_i), .rf_rd_o(rf_rd_o), .rf_rd_value_o(rf_rd_value_o),
    .rf_rd_write_o(rf_rd_write_o), .w_bus_error_o(w_bus_error_o)
  );
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_in;
    x_valid_i = 0; x_load_i = 0; x_store_i = 0;
    dm_load_done_i = 0; dm_store_done_i = 0;
  endtask
  task automatic issue(input logic ld, input logic st, input logic [2:0] fun, input logic [4:0] rd,
                       input logic [31:0] addr);
    x_valid_i = 1; x_load_i = ld; x_store_i = st; x_fun_i = fun;
    x_rd_i = rd; x_rd_write_i = ~st; x_dm_addr_i = addr;
  endtask
  initial begin
    rst_i = 1; w_stall_i = 0; idle_in();
    x_fun_i = 0; x_rd_i = 0; x_rd_write_i = 0; x_rd_source_i = 0;
    x_rd_value_i = 0; x_rd_shifter_i = 0; x_rd_multiply_i = 0; x_dm_addr_i = 0; dm_data_l_i = 0;
    #1;
    chk("rst_stall", 32'(w_stall_req_o), 0);
    chk("rst_rd", 32'(rf_rd_o), 0);
    chk("rst_val", rf_rd_value_o, 0);
    chk("rst_wr", 32'(rf_rd_write_o), 0);
    chk("rst_err", 32'(w_bus_error_o), 0);
    tick(); tick(); rst_i = 0; tick();
    // ALU, shifter, multiplier sources
    issue(0, 0, 0, 5, 0); x_rd_value_i = 32'h1234; x_rd_shifter_i = 32'h5555; x_rd_multiply_i = 32'h6666;
    #1 chk("alu_stall", 32'(w_stall_req_o), 0);
    tick(); idle_in();
    chk("alu_rd", 32'(rf_rd_o), 5);
    chk("alu_val", rf_rd_value_o, 32'h1234);
    chk("alu_wr", 32'(rf_rd_write_o), 1);
    tick();
    chk("alu_wr_once", 32'(rf_rd_write_o), 0);
    issue(0, 0, 0, 7, 0); x_rd_source_i = 2; x_rd_shifter_i = 32'hDEAD0000;
    tick(); idle_in();
    chk("shf_val", rf_rd_value_o, 32'hDEAD0000);
    issue(0, 0, 0, 8, 0); x_rd_source_i = 3; x_rd_multiply_i = 32'h0BADF00D;
    tick(); idle_in();
    chk("mul_val", rf_rd_value_o, 32'h0BADF00D);
    issue(0, 0, 0, 0, 0); x_rd_source_i = 0;
    tick(); idle_in();
    chk("alu_rd0_wr", 32'(rf_rd_write_o), 0);
    issue(0, 0, 0, 13, 0); w_stall_i = 1;
    tick(); idle_in(); w_stall_i = 0;
    chk("stall_blocks_wr", 32'(rf_rd_write_o), 0);
    // LB with done three wait cycles late; the done lands on the timeout cycle and wins
    issue(1, 0, 3'b000, 9, 32'h103);
    tick(); idle_in();
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall", 32'(w_stall_req_o), 1);
      tick();
    end
    dm_load_done_i = 1; dm_data_l_i = 32'h80AA5511; w_stall_i = 1;
    #1 chk("lb_stall_drop", 32'(w_stall_req_o), 0);
    tick(); idle_in(); w_stall_i = 0;
    chk("lb_rd", 32'(rf_rd_o), 9);
    chk("lb_val", rf_rd_value_o, 32'hFFFFFF80);
    chk("lb_wr", 32'(rf_rd_write_o), 1);
    chk("lb_err", 32'(w_bus_error_o), 0);
    // LHU with same-cycle done
    issue(1, 0, 3'b101, 10, 32'h102); dm_load_done_i = 1; dm_data_l_i = 32'hBEEF0000;
    #1 chk("lhu_stall", 32'(w_stall_req_o), 0);
    tick(); idle_in();
    chk("lhu_val", rf_rd_value_o, 32'h0000BEEF);
    chk("lhu_wr", 32'(rf_rd_write_o), 1);
    chk("lhu_idle", 32'(w_stall_req_o), 0);
    issue(1, 0, 3'b001, 11, 32'h100); dm_load_done_i = 1; dm_data_l_i = 32'h12348001;
    tick(); idle_in();
    chk("lh_val", rf_rd_value_o, 32'hFFFF8001);
    issue(1, 0, 3'b100, 11, 32'h101); dm_load_done_i = 1; dm_data_l_i = 32'h12348001;
    tick(); idle_in();
    chk("lbu_val", rf_rd_value_o, 32'h00000080);
    issue(1, 0, 3'b010, 0, 32'h100); dm_load_done_i = 1; dm_data_l_i = 32'hFFFFFFFF;
    tick(); idle_in();
    chk("lw_rd0_wr", 32'(rf_rd_write_o), 0);
    // store timeout
    issue(0, 1, 3'b010, 4, 32'h200);
    tick(); idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("st_stall", 32'(w_stall_req_o), 1);
      chk("st_err_early", 32'(w_bus_error_o), 0);
      tick();
    end
    chk("st_to_stall", 32'(w_stall_req_o), 0);
    chk("st_to_err", 32'(w_bus_error_o), 1);
    chk("st_to_wr", 32'(rf_rd_write_o), 0);
    tick();
    chk("st_err_once", 32'(w_bus_error_o), 0);
    // load timeout writes zero
    x_rd_source_i = 0; x_rd_value_i = 32'h77;
    issue(0, 0, 0, 12, 0);
    tick(); idle_in();
    issue(1, 0, 3'b010, 12, 32'h300);
    tick(); idle_in();
    for (int i = 0; i < 4; i++) tick();
    chk("ld_to_err", 32'(w_bus_error_o), 1);
    chk("ld_to_wr", 32'(rf_rd_write_o), 1);
    chk("ld_to_val", rf_rd_value_o, 0);
    // reset during LOAD_WAIT
    x_rd_value_i = 32'hCAFE;
    issue(0, 0, 0, 3, 0);
    tick(); idle_in();
    issue(1, 0, 3'b010, 14, 32'h400);
    tick(); idle_in();
    chk("rw_stall", 32'(w_stall_req_o), 1);
    chk("rw_pre_val", rf_rd_value_o, 32'hCAFE);
    #2 rst_i = 1;
    #1 chk("rw_stall_rst", 32'(w_stall_req_o), 0);
    chk("rw_rd_rst", 32'(rf_rd_o), 0);
    chk("rw_val_rst", rf_rd_value_o, 0);
    tick(); rst_i = 0;
    dm_load_done_i = 1; dm_data_l_i = 32'h12345678;
    tick(); idle_in();
    chk("rw_late_wr", 32'(rf_rd_write_o), 0);
    chk("rw_late_stall", 32'(w_stall_req_o), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
